fetch_pc_unit: RTL and testbench

- Next-PC / fetch-address stage that closes the loop around the branch target buffer.
- Drives the fetch PC into the BTB and the I-cache each cycle, and consumes the BTB's registered next-PC, taken flag and flush.
- Absorbs pipeline stalls, which the BTB does not honour.
- Carries the fetched PC across the IF/ID boundary with a valid bit that is killed on a mispredict flush.

---
 rtl/fetch_pc_unit_pkg.sv | 13 +
 rtl/fetch_pc_unit_if_id_slot.sv | 50 +++++
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and defaults for the fetch PC unit: state encoding and address defaults.
package fetch_pc_unit_pkg;

  localparam int                 DEFAULT_ADDR_W       = 32;
  localparam logic [31:0]        DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if_id_slot.sv
// IF/ID pipeline register: PC, valid and taken-entry bits with load enable,
// synchronous clear and a combinational squash of the valid bit on flush.
module fetch_pc_unit_if_id_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load_en,
  input  logic         flush,
  input  logic [W-1:0] pc_in,
  input  logic         valid_in,
  input  logic         taken_in,
  output logic [W-1:0] pc_out,
  output logic         valid_out,
  output logic         taken_out
);

  logic [W-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         taken_q, taken_d;

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    taken_d = taken_q;
    if (load_en) begin
      pc_d    = pc_in;
      valid_d = valid_in;
      taken_d = taken_in;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
    end
  end

  // The wrong-path occupant is killed in the same cycle the flush arrives.
  assign valid_out = valid_q & ~flush;
  assign pc_out    = pc_q;
  assign taken_out = taken_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Next-PC / fetch-address stage closing the loop around the BTB, with stall hold.
// Optional fetch/redirect/stall counters are built when FETCH_STATS_EN is defined.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH_IN,
  input  logic              take_Branch_IN,
  input  logic [ADDR_W-1:0] take_Alt_PC_IN,
  output logic [ADDR_W-1:0] Instr_PC_OUT_IF,
  output logic              Fetch_Valid_OUT_IF,
  output logic [ADDR_W-1:0] Instr_PC_OUT_ID,
  output logic              Valid_OUT_ID,
`ifdef FETCH_STATS_EN
  output logic [31:0]       Fetch_Count_OUT,
  output logic [31:0]       Redirect_Count_OUT,
  output logic [31:0]       Stall_Count_OUT,
`endif
  output logic              Taken_Entry_OUT_ID
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc;
  logic              hold_req;
  logic              slot_load;
  logic              fetch_valid;

  // A flush always wins over a stall: the redirect must be fetched now.
  assign hold_req    = STALL & ~FLUSH_IN;
  assign slot_load   = ~hold_req;
  assign fetch_valid = slot_load & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = hold_req ? HOLD : RUN;
      RUN:     state_d = hold_req ? HOLD : RUN;
      HOLD:    state_d = hold_req ? HOLD : RUN;
      default: state_d = BOOT;
    endcase
  end

  // In HOLD the BTB is re-evaluating pc_q, so its output is next(pc_q) on release.
  always_comb begin
    if_pc = RESET_VECTOR;
    case (state_q)
      BOOT:    if_pc = RESET_VECTOR;
      RUN:     if_pc = take_Alt_PC_IN;
      HOLD:    if_pc = FLUSH_IN ? take_Alt_PC_IN : pc_q;
      default: if_pc = RESET_VECTOR;
    endcase
  end

  assign pc_d               = if_pc;
  assign Instr_PC_OUT_IF    = if_pc;
  assign Fetch_Valid_OUT_IF = fetch_valid;

  fetch_pc_unit_if_id_slot #(
    .W (ADDR_W)
  ) u_if_id_slot (
    .clk       (CLK),
    .srst      (RESET),
    .load_en   (slot_load),
    .flush     (FLUSH_IN),
    .pc_in     (if_pc),
    .valid_in  (fetch_valid),
    .taken_in  ((state_q != BOOT) & take_Branch_IN),
    .pc_out    (Instr_PC_OUT_ID),
    .valid_out (Valid_OUT_ID),
    .taken_out (Taken_Entry_OUT_ID)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q + {31'd0, fetch_valid};
    redirect_cnt_d = redirect_cnt_q + {31'd0, FLUSH_IN};
    stall_cnt_d    = stall_cnt_q + {31'd0, (state_q == HOLD)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign Fetch_Count_OUT    = fetch_cnt_q;
  assign Redirect_Count_OUT = redirect_cnt_q;
  assign Stall_Count_OUT    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot, stall hold, taken entry, flush squash,
// flush-over-stall, mid-run reset; counters checked when FETCH_STATS_EN is defined.
module tb_fetch_pc_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        FLUSH_IN;
  logic        take_Branch_IN;
  logic [31:0] take_Alt_PC_IN;
  logic [31:0] Instr_PC_OUT_IF;
  logic        Fetch_Valid_OUT_IF;
  logic [31:0] Instr_PC_OUT_ID;
  logic        Valid_OUT_ID;
  logic        Taken_Entry_OUT_ID;
`ifdef FETCH_STATS_EN
  logic [31:0] Fetch_Count_OUT;
  logic [31:0] Redirect_Count_OUT;
  logic [31:0] Stall_Count_OUT;
`endif

  int tests_run  = 0;
  int fail_count = 0;

  always #5 CLK = ~CLK;

  fetch_pc_unit #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0100)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .STALL              (STALL),
    .FLUSH_IN           (FLUSH_IN),
    .take_Branch_IN     (take_Branch_IN),
    .take_Alt_PC_IN     (take_Alt_PC_IN),
    .Instr_PC_OUT_IF    (Instr_PC_OUT_IF),
    .Fetch_Valid_OUT_IF (Fetch_Valid_OUT_IF),
    .Instr_PC_OUT_ID    (Instr_PC_OUT_ID),
    .Valid_OUT_ID       (Valid_OUT_ID),
`ifdef FETCH_STATS_EN
    .Fetch_Count_OUT    (Fetch_Count_OUT),
    .Redirect_Count_OUT (Redirect_Count_OUT),
    .Stall_Count_OUT    (Stall_Count_OUT),
`endif
    .Taken_Entry_OUT_ID (Taken_Entry_OUT_ID)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic stall, input logic flush,
                       input logic taken, input logic [31:0] alt);
    @(negedge CLK);
    RESET          = rst;
    STALL          = stall;
    FLUSH_IN       = flush;
    take_Branch_IN = taken;
    take_Alt_PC_IN = alt;
    #1;
  endtask

  task automatic expect_cycle(input string name, input logic [31:0] if_pc, input logic fv,
                              input logic [31:0] id_pc, input logic vid, input logic tid);
    chk({name, ".if_pc"},    Instr_PC_OUT_IF,           if_pc);
    chk({name, ".if_valid"}, {31'd0, Fetch_Valid_OUT_IF}, {31'd0, fv});
    chk({name, ".id_pc"},    Instr_PC_OUT_ID,           id_pc);
    chk({name, ".id_valid"}, {31'd0, Valid_OUT_ID},       {31'd0, vid});
    chk({name, ".id_taken"}, {31'd0, Taken_Entry_OUT_ID}, {31'd0, tid});
    $display("[TB] %s IF=0x%08h fv=%0b ID=0x%08h v=%0b t=%0b", name, Instr_PC_OUT_IF,
             Fetch_Valid_OUT_IF, Instr_PC_OUT_ID, Valid_OUT_ID, Taken_Entry_OUT_ID);
  endtask

  initial begin
    RESET          = 1'b1;
    STALL          = 1'b0;
    FLUSH_IN       = 1'b0;
    take_Branch_IN = 1'b0;
    take_Alt_PC_IN = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    expect_cycle("reset", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_STATS_EN
    chk("reset.fetch_cnt",    Fetch_Count_OUT,    32'd0);
    chk("reset.redirect_cnt", Redirect_Count_OUT, 32'd0);
    chk("reset.stall_cnt",    Stall_Count_OUT,    32'd0);
`endif

    // Boot: BTB output (even a taken flag) ignored, then sequential PC+4.
    drive(0, 0, 0, 1, 32'hDEAD); expect_cycle("c0_boot", 32'h100, 1, 32'h0,   0, 0);
    drive(0, 0, 0, 0, 32'h104);  expect_cycle("c1_seq",  32'h104, 1, 32'h100, 1, 0);
    // Stall three cycles with IF at 0x108, then release without a bubble.
    drive(0, 1, 0, 0, 32'h108);  expect_cycle("c2_stl",  32'h108, 0, 32'h104, 1, 0);
    drive(0, 1, 0, 0, 32'h10C);  expect_cycle("c3_stl",  32'h108, 0, 32'h104, 1, 0);
    drive(0, 1, 0, 0, 32'h10C);  expect_cycle("c4_stl",  32'h108, 0, 32'h104, 1, 0);
    drive(0, 0, 0, 0, 32'h10C);  expect_cycle("c5_rel",  32'h108, 1, 32'h104, 1, 0);
    drive(0, 0, 0, 0, 32'h10C);  expect_cycle("c6_seq",  32'h10C, 1, 32'h108, 1, 0);
    // Taken prediction into 0x200.
    drive(0, 0, 0, 1, 32'h200);  expect_cycle("c7_tkn",  32'h200, 1, 32'h10C, 1, 0);
    drive(0, 0, 0, 0, 32'h204);  expect_cycle("c8_tid",  32'h204, 1, 32'h200, 1, 1);
    // Mispredict flush to 0x400 squashes the ID occupant.
    drive(0, 0, 1, 1, 32'h400);  expect_cycle("c9_fl",   32'h400, 1, 32'h204, 0, 0);
    drive(0, 1, 0, 0, 32'h404);  expect_cycle("c10_stl", 32'h404, 0, 32'h400, 1, 1);
    // Flush while stalled in HOLD: redirect wins and the state returns to RUN.
    drive(0, 1, 1, 1, 32'h480);  expect_cycle("c11_fst", 32'h480, 1, 32'h400, 0, 1);
    // RUN presents take_Alt_PC_IN; reset asserted mid-run kills fetch valid.
    drive(1, 0, 0, 0, 32'h484);  expect_cycle("c12_rst", 32'h484, 0, 32'h480, 1, 1);
    drive(0, 0, 0, 0, 32'h999);  expect_cycle("c13_bt",  32'h100, 1, 32'h0,   0, 0);
    drive(0, 0, 0, 0, 32'h104);  expect_cycle("c14_seq", 32'h104, 1, 32'h100, 1, 0);
    drive(0, 1, 0, 0, 32'h108);  expect_cycle("c15_stl", 32'h108, 0, 32'h104, 1, 0);
    drive(0, 1, 0, 0, 32'h10C);  expect_cycle("c16_stl", 32'h108, 0, 32'h104, 1, 0);
    drive(0, 0, 0, 0, 32'h10C);  expect_cycle("c17_rel", 32'h108, 1, 32'h104, 1, 0);
    drive(0, 0, 1, 1, 32'h300);  expect_cycle("c18_fl",  32'h300, 1, 32'h108, 0, 0);
    drive(0, 0, 0, 0, 32'h304);  expect_cycle("c19_seq", 32'h304, 1, 32'h300, 1, 1);
    drive(0, 0, 0, 0, 32'h308);  expect_cycle("c20_seq", 32'h308, 1, 32'h304, 1, 0);
    drive(0, 0, 0, 0, 32'h30C);  expect_cycle("c21_seq", 32'h30C, 1, 32'h308, 1, 0);
    drive(0, 0, 0, 0, 32'h310);  expect_cycle("c22_seq", 32'h310, 1, 32'h30C, 1, 0);
    drive(0, 0, 0, 0, 32'h314);  expect_cycle("c23_seq", 32'h314, 1, 32'h310, 1, 0);
`ifdef FETCH_STATS_EN
    // Cycles c13..c22: ten cycles, two without fetch, two in HOLD, one flush.
    chk("stats.fetch_cnt",    Fetch_Count_OUT,    32'd8);
    chk("stats.redirect_cnt", Redirect_Count_OUT, 32'd1);
    chk("stats.stall_cnt",    Stall_Count_OUT,    32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
